// File: rtl/mlp_layer_sequencer.sv
// Layer-by-layer controller for an N-neuron MLP datapath: loads the input, then sequences
// fetch / neuron-latency wait / write-back per weight layer, and hands out the final vector.
module mlp_layer_sequencer #(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int QM      = 3,
    parameter int QN      = 5,
    parameter int NEU_LAT = 2,
    localparam int DW     = QM + QN,
    localparam int LAW    = (M > 2) ? $clog2(M - 1) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         load_x,
    output logic                         read_en,
    output logic                         write_en,
    output logic [LAW-1:0]               layer_addr,
    input  logic signed [N-1:0][DW-1:0]  result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [N-1:0][DW-1:0]  out_data
);

    localparam int CW = (NEU_LAT > 1) ? $clog2(NEU_LAT) : 1;
    localparam logic [LAW-1:0] LAST_LAYER = LAW'(M - 2);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(NEU_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_COMPUTE,
        S_WB,
        S_OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [LAW-1:0]                layer_q, layer_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic signed [N-1:0][DW-1:0]   out_data_q, out_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            layer_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                layer_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                cnt_d   = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                // Leave after exactly NEU_LAT cycles here, so WB lands on the first valid result.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                if (layer_q == LAST_LAYER) begin
                    out_data_d = result;
                    state_d    = S_OUT;
                end else begin
                    layer_d = layer_q + LAW'(1);
                    state_d = S_FETCH;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    layer_d = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is either a register or a pure decode of the state register.
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign load_x     = (state_q == S_LOAD);
    assign read_en    = (state_q == S_FETCH);
    assign write_en   = (state_q == S_WB);
    assign out_valid  = (state_q == S_OUT);
    assign layer_addr = layer_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: a 2-layer and a 4-layer instance share clock and reset.
module tb_mlp_layer_sequencer;

    logic clk;
    logic rst;

    logic            start2, ready2, busy2, done2, ld2, rd2, wr2, ov2;
    logic [0:0]      addr2;
    logic [1:0][7:0] res2, od2;

    logic            start4, ready4, busy4, done4, ld4, rd4, wr4, ov4;
    logic [1:0]      addr4;
    logic [1:0][7:0] res4, od4;

    int checks;
    int errors;

    mlp_layer_sequencer #(.M(2), .N(2), .QM(3), .QN(5), .NEU_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .load_x(ld2), .read_en(rd2), .write_en(wr2), .layer_addr(addr2),
        .result(res2), .out_valid(ov2), .out_ready(ready2), .out_data(od2)
    );

    mlp_layer_sequencer #(.M(4), .N(2), .QM(3), .QN(5), .NEU_LAT(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .load_x(ld4), .read_en(rd4), .write_en(wr4), .layer_addr(addr4),
        .result(res4), .out_valid(ov4), .out_ready(ready4), .out_data(od4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rd_n, ov_c, done_c, bad_addr, stable, n_ld, n_rd, n_wr, n_done;
        int rd_c[3];
        int rd_a[3];
        logic [15:0] od_cap;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        start2 = 1'b0; ready2 = 1'b0; res2 = 16'h0000;
        start4 = 1'b0; ready4 = 1'b0; res4 = 16'h0000;
        tick();
        tick();
        rst = 1'b0;

        // Power-on reset state
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_strobes2", 32'({done2, ld2, rd2, wr2, ov2}), 32'd0);
        check("rst_addr2", 32'(addr2), 32'd0);
        check("rst_od2", 32'(od2), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_addr4", 32'(addr4), 32'd0);

        // M=2 basic run
        start2 = 1'b1;
        tick();                                   // c1
        start2 = 1'b0;
        check("m2_load_c1", 32'(ld2), 32'd1);
        check("m2_busy_c1", 32'(busy2), 32'd1);
        tick();                                   // c2
        check("m2_read_c2", 32'(rd2), 32'd1);
        check("m2_addr_c2", 32'(addr2), 32'd0);
        tick();                                   // c3
        check("m2_quiet_c3", 32'({ld2, rd2, wr2, ov2}), 32'd0);
        res2 = 16'h10F8;
        tick();                                   // c4
        check("m2_quiet_c4", 32'({ld2, rd2, wr2, ov2}), 32'd0);
        tick();                                   // c5
        check("m2_write_c5", 32'(wr2), 32'd1);
        check("m2_noout_c5", 32'(ov2), 32'd0);
        tick();                                   // c6
        check("m2_valid_c6", 32'(ov2), 32'd1);
        check("m2_data_c6", 32'(od2), 32'h10F8);
        check("m2_nodone_c6", 32'(done2), 32'd0);
        ready2 = 1'b1;
        tick();                                   // c7
        ready2 = 1'b0;
        check("m2_done_c7", 32'(done2), 32'd1);
        check("m2_idle_c7", 32'({busy2, ov2}), 32'd0);
        tick();                                   // c8
        check("m2_done_pulse", 32'(done2), 32'd0);

        // M=4, NEU_LAT=3 layer sequencing
        rd_n = 0; ov_c = -1; done_c = -1; bad_addr = 0; od_cap = 16'h0;
        rd_c = '{default: -1};
        rd_a = '{default: -1};
        res4 = 16'h7F80;
        ready4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (rd4) begin
                if (rd_n < 3) begin
                    rd_c[rd_n] = c;
                    rd_a[rd_n] = int'(addr4);
                end
                rd_n++;
            end
            if (ov4 && ov_c < 0) begin
                ov_c = c;
                od_cap = od4;
            end
            if (done4 && done_c < 0) done_c = c;
            if (addr4 > 2'd2) bad_addr++;
            tick();
        end
        ready4 = 1'b0;
        check("m4_read_count", 32'(rd_n), 32'd3);
        check("m4_read0_cyc", 32'(rd_c[0]), 32'd2);
        check("m4_read1_cyc", 32'(rd_c[1]), 32'd7);
        check("m4_read2_cyc", 32'(rd_c[2]), 32'd12);
        check("m4_read0_addr", 32'(rd_a[0]), 32'd0);
        check("m4_read1_addr", 32'(rd_a[1]), 32'd1);
        check("m4_read2_addr", 32'(rd_a[2]), 32'd2);
        check("m4_valid_cyc", 32'(ov_c), 32'd17);
        check("m4_done_cyc", 32'(done_c), 32'd18);
        check("m4_data", 32'(od_cap), 32'h7F80);
        check("m4_addr_range", 32'(bad_addr), 32'd0);
        check("m4_addr_back0", 32'(addr4), 32'd0);

        // Backpressure on the M=2 instance
        res2 = 16'h8001;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 5; k++) tick();       // c6
        check("bp_valid", 32'(ov2), 32'd1);
        check("bp_data", 32'(od2), 32'h8001);
        res2 = 16'h5555;
        stable = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ov2 && od2 == 16'h8001 && !done2) stable++;
        end
        check("bp_stable", 32'(stable), 32'd10);
        ready2 = 1'b1;
        tick();
        ready2 = 1'b0;
        check("bp_done", 32'(done2), 32'd1);
        check("bp_released", 32'(ov2), 32'd0);

        // Reset in the middle of COMPUTE
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();                                   // c3, COMPUTE
        check("mid_busy", 32'(busy2), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy2), 32'd0);
        check("mid_rst_strobes", 32'({done2, ld2, rd2, wr2, ov2}), 32'd0);
        check("mid_rst_addr", 32'(addr2), 32'd0);
        check("mid_rst_od", 32'(od2), 32'd0);
        tick();
        check("mid_rst_stays_idle", 32'({busy2, ld2, rd2, wr2}), 32'd0);

        // start held high: back-to-back runs
        n_ld = 0; n_rd = 0; n_wr = 0; done_c = -1;
        res2 = 16'h0102;
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            n_ld += int'(ld2);
            n_rd += int'(rd2);
            n_wr += int'(wr2);
            if (done2 && done_c < 0) done_c = c;
            tick();
        end
        check("b2b_strobes", 32'({n_ld[3:0], n_rd[3:0], n_wr[3:0]}), 32'h111);
        check("b2b_done_cyc", 32'(done_c), 32'd7);
        check("b2b_reload_c8", 32'(ld2), 32'd1);
        start2 = 1'b0;
        done_c = -1;
        for (int c = 8; c <= 15; c++) begin
            if (done2 && done_c < 0) done_c = c;
            tick();
        end
        ready2 = 1'b0;
        check("b2b_second_done", 32'(done_c), 32'd14);
        check("b2b_idle", 32'(busy2), 32'd0);

        // start pulses while busy are ignored
        n_ld = 0; n_rd = 0; n_wr = 0; n_done = 0;
        ready4 = 1'b1;
        start4 = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            start4 = (c == 3 || c == 9);
            n_ld += int'(ld4);
            n_rd += int'(rd4);
            n_wr += int'(wr4);
            n_done += int'(done4);
            tick();
        end
        start4 = 1'b0;
        ready4 = 1'b0;
        check("ign_load", 32'(n_ld), 32'd1);
        check("ign_read", 32'(n_rd), 32'd3);
        check("ign_write", 32'(n_wr), 32'd3);
        check("ign_done", 32'(n_done), 32'd1);
        check("ign_idle", 32'(busy4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
